// File: rtl/spi_nibble_receiver.sv
// rtl/spi_nibble_receiver.sv - SPI mode-0 slave: syncs raw pins, deframes header+nibble bytes, returns ack on MISO
module spi_nibble_receiver #(
  parameter logic [3:0] HEADER      = 4'hA,
  parameter logic [3:0] ACK_HEADER  = 4'h5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       FPGA_clk,
  input  logic       FPGA_reset,
  input  logic       sclk_in,
  input  logic       mosi_in,
  input  logic       ss_n_in,
  output logic [3:0] spi_data_out,
  output logic       spi_data_valid_out,
  output logic       frame_error_out,
  output logic       miso_out
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT    = 2'd1;
  localparam logic [1:0] CHECK    = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_n_sync, fill;
  logic sclk_d, ss_n_d, mosi_d;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, armed;

  logic [1:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift;
  logic [3:0] last_payload;
  logic       overrun;

  // Edge strobes are registered so mosi_d lines up with sclk_rise.
  // armed blocks a frame start until ss_n has been seen high after reset.
  always_ff @(posedge FPGA_clk) begin
    if (FPGA_reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_n_sync <= '1;
      fill      <= '0;
      sclk_d    <= 1'b0;
      ss_n_d    <= 1'b1;
      mosi_d    <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_rise   <= 1'b0;
      ss_fall   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n_in};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_n_d    <= ss_n_sync[SYNC_STAGES-1];
      mosi_d    <= mosi_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
      ss_rise   <= ss_n_sync[SYNC_STAGES-1] & ~ss_n_d;
      ss_fall   <= ~ss_n_sync[SYNC_STAGES-1] & ss_n_d & armed;
      if (fill[SYNC_STAGES-1] && ss_n_sync[SYNC_STAGES-1]) armed <= 1'b1;
    end
  end

  always_ff @(posedge FPGA_clk) begin
    if (FPGA_reset) begin
      state              <= IDLE;
      bit_cnt            <= 4'd0;
      rx_shift           <= 8'h00;
      tx_shift           <= 8'h00;
      last_payload       <= 4'h0;
      overrun            <= 1'b0;
      spi_data_out       <= 4'h0;
      spi_data_valid_out <= 1'b0;
      frame_error_out    <= 1'b0;
      miso_out           <= 1'b0;
    end else begin
      spi_data_valid_out <= 1'b0;
      frame_error_out    <= 1'b0;
      case (state)
        IDLE: begin
          miso_out <= 1'b0;
          if (ss_fall) begin
            state    <= SHIFT;
            bit_cnt  <= 4'd0;
            tx_shift <= {ACK_HEADER, last_payload};
            miso_out <= ACK_HEADER[3];
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state    <= IDLE;
            miso_out <= 1'b0;
            if (bit_cnt != 4'd0) frame_error_out <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_d};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= CHECK;
          end else if (sclk_fall) begin
            // Rotate rather than shift; only bit 6 onwards is ever driven out.
            tx_shift <= {tx_shift[6:0], tx_shift[7]};
            miso_out <= tx_shift[6];
          end
        end
        CHECK: begin
          overrun <= 1'b0;
          if (rx_shift[7:4] == HEADER) begin
            spi_data_out       <= rx_shift[3:0];
            last_payload       <= rx_shift[3:0];
            spi_data_valid_out <= 1'b1;
          end else begin
            frame_error_out <= 1'b1;
          end
          if (ss_rise) begin
            state    <= IDLE;
            miso_out <= 1'b0;
          end else begin
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (ss_rise) begin
            state    <= IDLE;
            miso_out <= 1'b0;
          end else if (sclk_rise && !overrun) begin
            frame_error_out <= 1'b1;
            overrun         <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_nibble_receiver.sv
// tb/tb_spi_nibble_receiver.sv - randomized SPI frame bench with transaction-level reference model
module tb_spi_nibble_receiver;

  localparam int SS = 2;

  logic       FPGA_clk = 1'b0;
  logic       FPGA_reset;
  logic       sclk_in, mosi_in, ss_n_in;
  logic [3:0] spi_data_out;
  logic       spi_data_valid_out, frame_error_out, miso_out;

  spi_nibble_receiver #(.HEADER(4'hA), .ACK_HEADER(4'h5), .SYNC_STAGES(SS)) dut (
    .FPGA_clk           (FPGA_clk),
    .FPGA_reset         (FPGA_reset),
    .sclk_in            (sclk_in),
    .mosi_in            (mosi_in),
    .ss_n_in            (ss_n_in),
    .spi_data_out       (spi_data_out),
    .spi_data_valid_out (spi_data_valid_out),
    .frame_error_out    (frame_error_out),
    .miso_out           (miso_out)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge FPGA_clk) cyc <= cyc + 1;

  // Model: expected pulse events {is_error, data} and last accepted payload.
  logic [4:0] exp_q[$];
  logic [3:0] m_last;
  logic [3:0] prev_data;
  logic [7:0] miso_byte;
  int         last_valid_cyc;
  int         rise8_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=pulse required=none", name);
  endtask

  always @(negedge FPGA_clk) begin
    logic [4:0] e;
    if (!FPGA_reset) begin
      if (spi_data_valid_out && frame_error_out) fail_now("valid_error_overlap");
      if (spi_data_valid_out) begin
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) fail_now("unexpected_valid");
        else begin
          e = exp_q.pop_front();
          check("event_is_valid", {31'd0, e[4]}, 32'd0);
          check("valid_data", {28'd0, spi_data_out}, {28'd0, e[3:0]});
        end
      end else if (spi_data_out !== prev_data) begin
        check("data_held", {28'd0, spi_data_out}, {28'd0, prev_data});
      end
      if (frame_error_out) begin
        if (exp_q.size() == 0) fail_now("unexpected_error");
        else begin
          e = exp_q.pop_front();
          check("event_is_error", {31'd0, e[4]}, 32'd1);
        end
      end
      prev_data = spi_data_out;
    end
  end

  task automatic pulse_bit(input logic b, input int half, input int idx);
    mosi_in = b;
    repeat (half) @(negedge FPGA_clk);
    if (idx < 8) miso_byte[7-idx] = miso_out;
    sclk_in = 1'b1;
    if (idx == 7) rise8_cyc = cyc;
    repeat (half) @(negedge FPGA_clk);
    sclk_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] byte_v, input int nbits, input int half, input int gap);
    logic [7:0] ack;
    logic [7:0] mask;
    ack = {4'h5, m_last};
    if (nbits >= 1 && nbits <= 7) exp_q.push_back(5'h10);
    else if (nbits >= 8) begin
      if (byte_v[7:4] == 4'hA) begin
        exp_q.push_back({1'b0, byte_v[3:0]});
        m_last = byte_v[3:0];
      end else exp_q.push_back(5'h10);
      if (nbits > 8) exp_q.push_back(5'h10);
    end
    miso_byte = 8'h00;
    ss_n_in = 1'b0;
    repeat (8) @(negedge FPGA_clk);
    for (int i = 0; i < nbits; i++)
      pulse_bit((i < 8) ? byte_v[7-i] : 1'($urandom_range(0, 1)), half, i);
    repeat (half) @(negedge FPGA_clk);
    ss_n_in = 1'b1;
    repeat (gap + 12) @(negedge FPGA_clk);
    check("events_drained", exp_q.size(), 0);
    if (nbits > 0) begin
      mask = (nbits >= 8) ? 8'hFF : ~(8'hFF >> nbits);
      check("miso_ack", {24'd0, miso_byte & mask}, {24'd0, ack & mask});
    end
  endtask

  task automatic do_reset();
    FPGA_reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge FPGA_clk);
    check("reset_data", {28'd0, spi_data_out}, 32'd0);
    check("reset_valid", {31'd0, spi_data_valid_out}, 32'd0);
    check("reset_error", {31'd0, frame_error_out}, 32'd0);
    check("reset_miso", {31'd0, miso_out}, 32'd0);
    FPGA_reset = 1'b0;
    m_last = 4'h0;
    prev_data = 4'h0;
  endtask

  int nb_tab[8] = '{0, 3, 7, 8, 8, 8, 8, 9};

  initial begin
    logic [7:0] rb;
    sclk_in = 1'b0; mosi_in = 1'b0; ss_n_in = 1'b1;
    last_valid_cyc = 0; rise8_cyc = 0; miso_byte = 8'h00;
    do_reset();
    repeat (6) @(negedge FPGA_clk);

    send_frame(8'hA7, 8, 8, 6);
    check("a7_data", {28'd0, spi_data_out}, 32'h7);
    check("valid_latency", last_valid_cyc - rise8_cyc - 1, SS + 2);
    send_frame(8'h37, 8, 8, 6);
    check("bad_header_holds", {28'd0, spi_data_out}, 32'h7);
    send_frame(8'hA3, 8, 8, 6);
    check("miso_57", {24'd0, miso_byte}, 32'h57);
    check("a3_data", {28'd0, spi_data_out}, 32'h3);
    send_frame(8'hA0, 5, 6, 4);
    send_frame(8'hAC, 8, 5, 4);
    check("ac_data", {28'd0, spi_data_out}, 32'hC);
    send_frame(8'hA5, 9, 4, 4);
    check("a5_data", {28'd0, spi_data_out}, 32'h5);

    // Reset mid-frame with ss_n held low; later sclk edges must be ignored.
    ss_n_in = 1'b0;
    repeat (8) @(negedge FPGA_clk);
    for (int i = 0; i < 4; i++) pulse_bit(1'b1, 6, i);
    do_reset();
    for (int i = 0; i < 6; i++) pulse_bit(1'b1, 6, 8);
    repeat (12) @(negedge FPGA_clk);
    check("ignored_after_reset", exp_q.size(), 0);
    check("data_after_reset", {28'd0, spi_data_out}, 32'h0);
    ss_n_in = 1'b1;
    repeat (8) @(negedge FPGA_clk);
    send_frame(8'hA9, 8, 8, 6);
    check("a9_data", {28'd0, spi_data_out}, 32'h9);

    for (int k = 0; k < 24; k++) begin
      rb[7:4] = ($urandom_range(0, 1) != 0) ? 4'hA : 4'($urandom_range(0, 15));
      rb[3:0] = 4'($urandom_range(0, 15));
      send_frame(rb, nb_tab[$urandom_range(0, 7)], $urandom_range(4, 8), $urandom_range(4, 10));
      check("rand_held_data", {28'd0, spi_data_out}, {28'd0, m_last});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
